// File: rtl/fetch_redirect_unit.sv
// Fetch stage: owns the PC, fetches over a req/ack handshake, fills IF/ID (PR1) and applies branch redirects/flushes.
// Optional FETCH_NOP_ON_FLUSH_EN: a flush also zeroes PR1 data fields (NOP, PC+1 = 0).
module fetch_redirect_unit #(
    parameter int PC_W    = 12,
    parameter int INSTR_W = 19,
    parameter int OFF_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall_in,
    input  logic               sel_PC_src_offset,
    input  logic [PC_W-1:0]    redirect_base,
    input  logic [OFF_W-1:0]   redirect_offset,
    input  logic               flush_PR1,
    output logic [INSTR_W-1:0] pr1_instr,
    output logic [PC_W-1:0]    pr1_pc_plus1,
    output logic               pr1_valid
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DISCARD} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    req_addr_q, req_addr_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    logic [PC_W-1:0]    hold_pc1_q, hold_pc1_d;
    logic [INSTR_W-1:0] pr1_instr_q, pr1_instr_d;
    logic [PC_W-1:0]    pr1_pc1_q, pr1_pc1_d;
    logic               pr1_valid_q, pr1_valid_d;
    logic               imem_req_q, imem_req_d;

    logic [PC_W-1:0]    target;
    logic [PC_W-1:0]    next_addr;
    logic               pr1_load;
    logic [INSTR_W-1:0] load_instr;
    logic [PC_W-1:0]    load_pc1;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        target     = redirect_base + {{(PC_W-OFF_W){redirect_offset[OFF_W-1]}}, redirect_offset};
        next_addr  = req_addr_q + PC_W'(1);
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        hold_instr_d = hold_instr_q;
        hold_pc1_d = hold_pc1_q;
        pr1_load   = 1'b0;
        load_instr = imem_rdata;
        load_pc1   = next_addr;

        unique case (state_q)
            S_IDLE: begin
                state_d    = S_REQ;
                pc_d       = sel_PC_src_offset ? target : pc_q;
                req_addr_d = sel_PC_src_offset ? target : pc_q;
            end
            S_REQ: begin
                if (sel_PC_src_offset) begin
                    pc_d = target;
                    if (imem_ack) req_addr_d = target;
                    else          state_d    = S_DISCARD;
                end else if (imem_ack) begin
                    // pc moves past the fetched word even when stalled so HOLD exit resumes at the next one.
                    pc_d = next_addr;
                    if (stall_in) begin
                        hold_instr_d = imem_rdata;
                        hold_pc1_d   = next_addr;
                        state_d      = S_HOLD;
                    end else begin
                        pr1_load   = 1'b1;
                        req_addr_d = next_addr;
                    end
                end
            end
            S_HOLD: begin
                if (sel_PC_src_offset) begin
                    pc_d       = target;
                    req_addr_d = target;
                    state_d    = S_REQ;
                end else if (!stall_in) begin
                    pr1_load   = 1'b1;
                    load_instr = hold_instr_q;
                    load_pc1   = hold_pc1_q;
                    req_addr_d = pc_q;
                    state_d    = S_REQ;
                end
            end
            S_DISCARD: begin
                if (sel_PC_src_offset) pc_d = target;
                if (imem_ack) begin
                    req_addr_d = sel_PC_src_offset ? target : pc_q;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pr1_instr_d = pr1_instr_q;
        pr1_pc1_d   = pr1_pc1_q;
        pr1_valid_d = pr1_valid_q;
        if (flush_PR1) begin
            pr1_valid_d = 1'b0;
`ifdef FETCH_NOP_ON_FLUSH_EN
            pr1_instr_d = '0;
            pr1_pc1_d   = '0;
`else
            pr1_instr_d = pr1_instr_q;
            pr1_pc1_d   = pr1_pc1_q;
`endif
        end else if (pr1_load) begin
            pr1_instr_d = load_instr;
            pr1_pc1_d   = load_pc1;
            pr1_valid_d = 1'b1;
        end else if (!stall_in) begin
            // Decode consumes PR1 every unstalled cycle; with nothing new it becomes a bubble.
            pr1_valid_d = 1'b0;
        end

        imem_req_d = (state_d == S_REQ) || (state_d == S_DISCARD);
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            req_addr_q   <= '0;
            hold_instr_q <= '0;
            hold_pc1_q   <= '0;
            pr1_instr_q  <= '0;
            pr1_pc1_q    <= '0;
            pr1_valid_q  <= 1'b0;
            imem_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_pc1_q   <= hold_pc1_d;
            pr1_instr_q  <= pr1_instr_d;
            pr1_pc1_q    <= pr1_pc1_d;
            pr1_valid_q  <= pr1_valid_d;
            imem_req_q   <= imem_req_d;
        end
    end

    assign imem_req     = imem_req_q;
    assign imem_addr    = req_addr_q;
    assign pr1_instr    = pr1_instr_q;
    assign pr1_pc_plus1 = pr1_pc1_q;
    assign pr1_valid    = pr1_valid_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit: directed plan steps, then random traffic against a behavioural model.
module tb_fetch_redirect_unit;

    localparam int PC_W = 12, INSTR_W = 19, OFF_W = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall_in;
    logic               sel_PC_src_offset;
    logic [PC_W-1:0]    redirect_base;
    logic [OFF_W-1:0]   redirect_offset;
    logic               flush_PR1;
    logic [INSTR_W-1:0] pr1_instr;
    logic [PC_W-1:0]    pr1_pc_plus1;
    logic               pr1_valid;

    fetch_redirect_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .OFF_W(OFF_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall_in(stall_in), .sel_PC_src_offset(sel_PC_src_offset),
        .redirect_base(redirect_base), .redirect_offset(redirect_offset), .flush_PR1(flush_PR1),
        .pr1_instr(pr1_instr), .pr1_pc_plus1(pr1_pc_plus1), .pr1_valid(pr1_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: where the fetcher is in the instruction stream, not how it is encoded.
    bit                 m_started, m_hold_full, m_drop;
    logic [PC_W-1:0]    m_pc, m_addr, m_hold_pc1, p_pc1;
    logic [INSTR_W-1:0] m_hold_instr, p_instr;
    bit                 p_valid;

    function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] a);
        return INSTR_W'(a * 37 + 19'h1234);
    endfunction

    function automatic bit m_req();
        return m_started && !m_hold_full;
    endfunction

    task automatic model_reset();
        m_started = 0; m_hold_full = 0; m_drop = 0;
        m_pc = '0; m_addr = '0; m_hold_pc1 = '0; m_hold_instr = '0;
        p_instr = '0; p_pc1 = '0; p_valid = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: compare at the negedge, drive inputs, advance the model, wait for the next negedge.
    task automatic step(input bit ack_i, input bit stall_i, input bit redir_i,
                        input logic [PC_W-1:0] base, input logic [OFF_W-1:0] off, input bit flush_i);
        logic [PC_W-1:0]    tgt;
        logic [INSTR_W-1:0] lin;
        logic [PC_W-1:0]    lpc;
        bit                 load, ack;
        check("imem_req", 32'(imem_req), 32'(m_req()));
        if (m_req()) check("imem_addr", 32'(imem_addr), 32'(m_addr));
        check("pr1_valid", 32'(pr1_valid), 32'(p_valid));
        check("pr1_instr", 32'(pr1_instr), 32'(p_instr));
        check("pr1_pc_plus1", 32'(pr1_pc_plus1), 32'(p_pc1));

        ack               = ack_i && m_req();
        imem_ack          = ack;
        imem_rdata        = ack ? instr_of(m_addr) : INSTR_W'($urandom);
        stall_in          = stall_i;
        sel_PC_src_offset = redir_i;
        redirect_base     = base;
        redirect_offset   = off;
        flush_PR1         = flush_i;

        tgt  = base + PC_W'(signed'(off));
        load = 0; lin = '0; lpc = '0;
        if (!m_started) begin
            m_started = 1;
            if (redir_i) m_pc = tgt;
            m_addr = m_pc;
        end else if (m_hold_full) begin
            if (redir_i) begin
                m_hold_full = 0; m_pc = tgt; m_addr = tgt;
            end else if (!stall_i) begin
                load = 1; lin = m_hold_instr; lpc = m_hold_pc1;
                m_hold_full = 0; m_addr = m_pc;
            end
        end else if (m_drop) begin
            if (redir_i) m_pc = tgt;
            if (ack) begin m_drop = 0; m_addr = m_pc; end
        end else begin
            if (redir_i) begin
                m_pc = tgt;
                if (ack) m_addr = tgt; else m_drop = 1;
            end else if (ack) begin
                m_pc = m_addr + 1'b1;
                if (stall_i) begin
                    m_hold_full = 1; m_hold_instr = imem_rdata; m_hold_pc1 = m_addr + 1'b1;
                end else begin
                    load = 1; lin = imem_rdata; lpc = m_addr + 1'b1;
                    m_addr = m_addr + 1'b1;
                end
            end
        end

        if (flush_i) begin
            p_valid = 0;
`ifdef FETCH_NOP_ON_FLUSH_EN
            p_instr = '0; p_pc1 = '0;
`endif
        end else if (load) begin
            p_valid = 1; p_instr = lin; p_pc1 = lpc;
        end else if (!stall_i) begin
            p_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic quiet(input bit ack_i, input bit stall_i);
        step(ack_i, stall_i, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 0; imem_rdata = '0; stall_in = 0; sel_PC_src_offset = 0;
        redirect_base = '0; redirect_offset = '0; flush_PR1 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_valid", 32'(pr1_valid), 32'd0);
        check("rst_pc1", 32'(pr1_pc_plus1), 32'd0);

        // Ack tied high: addresses 0,1,2,... and PR1 PC+1 = 1,2,3...
        quiet(1, 0);
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", 32'(imem_addr), 32'd0);
        quiet(1, 0);
        check("seq_addr1", 32'(imem_addr), 32'd1);
        check("seq_pc1_1", 32'(pr1_pc_plus1), 32'd1);
        check("seq_valid1", 32'(pr1_valid), 32'd1);
        repeat (4) quiet(1, 0);
        check("seq_addr5", 32'(imem_addr), 32'd5);

        // Ack delayed three cycles on address 5.
        repeat (3) begin
            quiet(0, 0);
            check("wait_addr5", 32'(imem_addr), 32'd5);
        end
        quiet(1, 0);
        check("ack5_pc1", 32'(pr1_pc_plus1), 32'd6);
        quiet(0, 0);
        check("ack5_once", 32'(pr1_valid), 32'd0);

        // Redirect to 0x012 (with ack), then redirect to 0x010-4 while 0x012 is pending.
        step(1, 0, 1, 12'h012, 8'h00, 0);
        check("redir_addr12", 32'(imem_addr), 32'h012);
        step(0, 0, 1, 12'h010, 8'hFC, 0);
        check("discard_addr", 32'(imem_addr), 32'h012);
        check("discard_req", 32'(imem_req), 32'd1);
        quiet(1, 0);
        check("redir_addr0c", 32'(imem_addr), 32'h00C);
        check("dropped_valid", 32'(pr1_valid), 32'd0);

        // Ack under stall: hold four cycles, then load held data.
        quiet(1, 1);
        repeat (3) begin
            check("hold_noreq", 32'(imem_req), 32'd0);
            quiet(0, 1);
        end
        quiet(0, 0);
        check("hold_pc1", 32'(pr1_pc_plus1), 32'h00D);
        check("hold_valid", 32'(pr1_valid), 32'd1);
        check("hold_resume", 32'(imem_addr), 32'h00D);

        // Flush together with stall while PR1 is valid.
        step(1, 1, 0, '0, '0, 1);
        check("flush_valid", 32'(pr1_valid), 32'd0);
`ifdef FETCH_NOP_ON_FLUSH_EN
        check("flush_nop", 32'(pr1_instr), 32'd0);
`endif
        repeat (3) quiet(0, 0);

        // Sequential fetch across 0xFFF.
        step(1, 0, 1, 12'hFFE, 8'h01, 0);
        check("wrap_addr_fff", 32'(imem_addr), 32'hFFF);
        quiet(1, 0);
        check("wrap_addr0", 32'(imem_addr), 32'h000);
        check("wrap_pc1", 32'(pr1_pc_plus1), 32'h000);

        // Asynchronous reset mid-request.
        quiet(0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_req", 32'(imem_req), 32'd0);
        check("async_addr", 32'(imem_addr), 32'd0);
        check("async_valid", 32'(pr1_valid), 32'd0);
        @(negedge clk);
        do_reset();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(1, 0) == 1, $urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0,
                 PC_W'($urandom), OFF_W'($urandom), $urandom_range(7, 0) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_unit.md
# fetch_redirect_unit

Fetch-side counterpart to the branch resolution logic. It owns the program counter, issues instruction-memory requests over a req/ack handshake, fills pipeline register PR1 (IF/ID) and acts on the redirect/flush commands from branch resolution (`sel_PC_src_offset`, `flush_PR1`). It sits between instruction memory and the decode stage.

## Interface
- `PC_W`, 12, program-counter / instruction-address width
- `INSTR_W`, 19, instruction width
- `OFF_W`, 8, branch offset width (two's complement)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  PC_W  fetch address; stable while `imem_req`=1 until ack
- `imem_ack`  in  1  `imem_rdata` valid this cycle; completes the request
- `imem_rdata`  in  INSTR_W  fetched instruction
- `stall_in`  in  1  hazard stall: PR1 must hold
- `sel_PC_src_offset`  in  1  redirect to the branch target
- `redirect_base`  in  PC_W  PC+1 of the resolving branch
- `redirect_offset`  in  OFF_W  branch offset
- `flush_PR1`  in  1  invalidate PR1 contents
- `pr1_instr`  out  INSTR_W  IF/ID instruction
- `pr1_pc_plus1`  out  PC_W  IF/ID PC+1
- `pr1_valid`  out  1  IF/ID holds a live instruction

## Operation
- Registers: `pc`, `req_addr`, hold buffer (instr + PC+1), PR1, FSM state.
- Target = `redirect_base` + sign-extend(`redirect_offset`), modulo 2^PC_W (wraps; no overflow flag).
- PC increment = `pc`+1 modulo 2^PC_W; 2^PC_W−1 wraps to 0.
- FSM states:
  - IDLE: `imem_req`=0; next state REQ, unless `sel_PC_src_offset`=1, which loads `pc`←target and then goes to REQ.
  - REQ: `imem_req`=1, `imem_addr`=`req_addr`. On ack with `stall_in`=0: PR1←{rdata, req_addr+1, valid=1}; `pc`,`req_addr`←req_addr+1; stay in REQ. On ack with `stall_in`=1: hold buffer←data, go to HOLD. No ack: wait.
  - HOLD: `imem_req`=0; PR1 frozen. When `stall_in`=0: PR1←hold buffer, `req_addr`←`pc`, go to REQ.
  - DISCARD: `imem_req`=1 with the old `req_addr` unchanged; on ack, drop data, `req_addr`←`pc`, go to REQ.
- Redirect (`sel_PC_src_offset`=1) overrides stall and ack:
  - REQ without ack → `pc`←target, go to DISCARD.
  - REQ with ack → drop data, `pc`,`req_addr`←target, stay in REQ.
  - HOLD → drop the hold buffer, `pc`,`req_addr`←target, go to REQ.
  - DISCARD → `pc`←target (latest wins), stay in DISCARD until ack.
- `flush_PR1`=1 forces `pr1_valid`←0 regardless of `stall_in`, and blocks the same-edge PR1 load.
- `stall_in` never stops an outstanding request from completing.

## Timing
- Reset (async, immediate): `pc`=0, `req_addr`=0, state=IDLE, `imem_req`=0, `imem_addr`=0, `pr1_instr`=0, `pr1_pc_plus1`=0, `pr1_valid`=0, hold buffer cleared.
- First request is in the 2nd cycle after `rst_n` deasserts (IDLE lasts one cycle).
- Ack in cycle N → `pr1_valid`=1 in N+1. The next address is presented in N+1. Throughput is 1 instruction per cycle with same-cycle ack.
- Redirect in cycle N with no outstanding request → `imem_addr`=target in N+1.
- `imem_addr` changes only in the cycle after an ack, or after IDLE/HOLD exit. It never changes while a request is pending.
- `rst_n` low mid-request abandons the request. The environment must drop a pending ack.

## Configuration
- `FETCH_NOP_ON_FLUSH_EN` defined: a flush also loads `pr1_instr`←0 (NOP) and `pr1_pc_plus1`←0.
- `FETCH_NOP_ON_FLUSH_EN` undefined: a flush clears only `pr1_valid`; the data fields keep their previous values.

## Test plan
- Reset release with ack tied to 1 → addresses 0,1,2,… from cycle 2; `pr1_pc_plus1` equals 1,2,3 one cycle later.
- Ack delayed 3 cycles on address 5 → `imem_addr`=5 held for 3 cycles; PR1 loads once.
- Redirect with base=0x010 and offset=0xFC while the request for 0x012 is pending without ack → ack data dropped; next request is 0x00C; `pr1_valid` never shows the 0x012 fetch.
- Ack while `stall_in`=1 for 4 cycles → HOLD; PR1 unchanged; no request; PR1 loads the held data the cycle stall drops.
- `flush_PR1` and `stall_in` together with `pr1_valid`=1 → `pr1_valid`=0 next cycle. With the macro defined, `pr1_instr`=0.
- Sequential fetch at 0xFFF → next address 0x000, `pr1_pc_plus1`=0x000.
